alu_op_sequencer: RTL and testbench

//  Initiator side of the 4-bit ALU interface. Accepts one operation request (A, B, op) over a

---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator for an external combinational ALU: accepts one request, drives registered operands,
// waits SETTLE cycles, then captures the result and returns it with zero/negative flags.
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic [1:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_neg_q, rsp_neg_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Next-state and output logic; ready/busy are registered from the next state so they never glitch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_z_d     = rsp_z_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_op_d    = rsp_op_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d    = req_a;
          alu_b_d    = req_b;
          alu_ctrl_d = req_op;
          cnt_d      = SETTLE_M1;
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_z_d     = alu_z;
          rsp_zero_d  = (alu_z == {WIDTH{1'b0}});
          rsp_neg_d   = alu_z[WIDTH-1];
          rsp_op_d    = alu_ctrl_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d       = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= {WIDTH{1'b0}};
      alu_b_q     <= {WIDTH{1'b0}};
      alu_ctrl_q  <= 2'd0;
      rsp_z_q     <= {WIDTH{1'b0}};
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_op_q    <= 2'd0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      op_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_z_q     <= rsp_z_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_op_q    <= rsp_op_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_op    = rsp_op_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE=1/CNT_W=8 and SETTLE=3/CNT_W=2) checked every
// cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [3:0] req_a     [2];
  logic [3:0] req_b     [2];
  logic [1:0] req_op    [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [1:0] alu_ctrl  [2];
  logic [3:0] alu_z     [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [3:0] rsp_z     [2];
  logic       rsp_zero  [2];
  logic       rsp_neg   [2];
  logic [1:0] rsp_op    [2];
  logic       busy      [2];
  logic       corrupt   [2];
  logic [7:0] oc0;
  logic [1:0] oc1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a & b;
      2'd2:    return a << b;
      default: return a >> b;
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cnt_mod(input int k);
    return (k == 0) ? 256 : 4;
  endfunction

  // The external ALU; corrupt inverts its output to prove capture timing.
  assign alu_z[0] = corrupt[0] ? ~alu_f(alu_a[0], alu_b[0], alu_ctrl[0]) : alu_f(alu_a[0], alu_b[0], alu_ctrl[0]);
  assign alu_z[1] = corrupt[1] ? ~alu_f(alu_a[1], alu_b[1], alu_ctrl[1]) : alu_f(alu_a[1], alu_b[1], alu_ctrl[1]);

  alu_op_sequencer #(.WIDTH(4), .SETTLE(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]), .alu_z(alu_z[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_z(rsp_z[0]),
    .rsp_zero(rsp_zero[0]), .rsp_neg(rsp_neg[0]), .rsp_op(rsp_op[0]),
    .busy(busy[0]), .op_count(oc0)
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]), .alu_z(alu_z[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_z(rsp_z[1]),
    .rsp_zero(rsp_zero[1]), .rsp_neg(rsp_neg[1]), .rsp_op(rsp_op[1]),
    .busy(busy[1]), .op_count(oc1)
  );

  // Transaction model: an accepted op owes its result SETTLE edges later and is retired by a handshake.
  logic       m_inflight [2];
  int         m_rsp_at   [2];
  logic [3:0] m_a        [2];
  logic [3:0] m_b        [2];
  logic [1:0] m_op       [2];
  logic [3:0] m_z        [2];
  logic       m_zero     [2];
  logic       m_neg      [2];
  logic [1:0] m_zop      [2];
  int         m_cnt      [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_inflight[k] <= 1'b0;
        m_rsp_at[k]   <= 0;
        m_a[k]        <= 4'd0;
        m_b[k]        <= 4'd0;
        m_op[k]       <= 2'd0;
        m_z[k]        <= 4'd0;
        m_zero[k]     <= 1'b0;
        m_neg[k]      <= 1'b0;
        m_zop[k]      <= 2'd0;
        m_cnt[k]      <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        if (!m_inflight[k]) begin
          if (req_valid[k]) begin
            m_inflight[k] <= 1'b1;
            m_a[k]        <= req_a[k];
            m_b[k]        <= req_b[k];
            m_op[k]       <= req_op[k];
            m_rsp_at[k]   <= cyc + 1 + settle_of(k);
          end
        end else begin
          if (cyc + 1 == m_rsp_at[k]) begin
            m_z[k]    <= alu_f(m_a[k], m_b[k], m_op[k]);
            m_zero[k] <= (alu_f(m_a[k], m_b[k], m_op[k]) == 4'd0);
            m_neg[k]  <= alu_f(m_a[k], m_b[k], m_op[k]) >= 4'd8;
            m_zop[k]  <= m_op[k];
          end
          if (cyc + 1 > m_rsp_at[k] && rsp_ready[k]) begin
            m_inflight[k] <= 1'b0;
            m_cnt[k]      <= (m_cnt[k] + 1) % cnt_mod(k);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("req_ready", k, 32'(req_ready[k]), 32'(!m_inflight[k]));
      chk("busy",      k, 32'(busy[k]),      32'(m_inflight[k]));
      chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_inflight[k] && (cyc >= m_rsp_at[k])));
      chk("alu_a",     k, 32'(alu_a[k]),     32'(m_a[k]));
      chk("alu_b",     k, 32'(alu_b[k]),     32'(m_b[k]));
      chk("alu_ctrl",  k, 32'(alu_ctrl[k]),  32'(m_op[k]));
      chk("rsp_z",     k, 32'(rsp_z[k]),     32'(m_z[k]));
      chk("rsp_zero",  k, 32'(rsp_zero[k]),  32'(m_zero[k]));
      chk("rsp_neg",   k, 32'(rsp_neg[k]),   32'(m_neg[k]));
      chk("rsp_op",    k, 32'(rsp_op[k]),    32'(m_zop[k]));
      chk("op_count",  k, (k == 0) ? 32'(oc0) : 32'(oc1), 32'(m_cnt[k]));
    end
  end

  task automatic send(input int k, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, output int t);
    int n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout[%0d]: req_ready still 0 after %0d cycles", k, n);
    end
    req_valid[k] = 1'b1;
    req_a[k]     = a;
    req_b[k]     = b;
    req_op[k]    = op;
    @(negedge clk);
    req_valid[k] = 1'b0;
    t = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int tprev;
    int exp6 [5] = '{1, 2, 3, 0, 1};
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_a[k] = 4'd0; req_b[k] = 4'd0; req_op[k] = 2'd0;
      rsp_ready[k] = 1'b0; corrupt[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("rst_op_count",  0, 32'(oc0), 32'd0);
    rst_n = 1'b1;

    // 3+4 with one settle cycle
    rsp_ready[0] = 1'b1;
    send(0, 4'd3, 4'd4, 2'd0, t);
    chk("t1_valid_T", 0, 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid_T1", 0, 32'(rsp_valid[0]), 32'd1);
    chk("t1_z",    0, 32'(rsp_z[0]), 32'd7);
    chk("t1_zero", 0, 32'(rsp_zero[0]), 32'd0);
    chk("t1_neg",  0, 32'(rsp_neg[0]), 32'd0);
    @(negedge clk);
    chk("t1_count", 0, 32'(oc0), 32'd1);

    send(0, 4'd5, 4'd3, 2'd0, t);
    @(negedge clk);
    chk("t2_z",   0, 32'(rsp_z[0]), 32'h8);
    chk("t2_neg", 0, 32'(rsp_neg[0]), 32'd1);
    @(negedge clk);
    send(0, 4'd6, 4'd9, 2'd1, t);
    @(negedge clk);
    chk("t2_and_z",    0, 32'(rsp_z[0]), 32'd0);
    chk("t2_and_zero", 0, 32'(rsp_zero[0]), 32'd1);
    @(negedge clk);

    // response back-pressure with an ignored request in the middle
    rsp_ready[0] = 1'b0;
    send(0, 4'd1, 4'd2, 2'd2, t);
    @(negedge clk);
    chk("t3_z0", 0, 32'(rsp_z[0]), 32'd4);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i == 1);
      req_a[0] = 4'hf; req_b[0] = 4'hf; req_op[0] = 2'd0;
      @(negedge clk);
      chk("t3_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("t3_z",     0, 32'(rsp_z[0]), 32'd4);
      chk("t3_ready", 0, 32'(req_ready[0]), 32'd0);
      chk("t3_count", 0, 32'(oc0), 32'd3);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_count_rel", 0, 32'(oc0), 32'd4);
    chk("t3_z_hold",    0, 32'(rsp_z[0]), 32'd4);

    // SETTLE=3 with the ALU output disturbed until the last waiting edge
    rsp_ready[1] = 1'b1;
    send(1, 4'h8, 4'd1, 2'd3, t);
    corrupt[1] = 1'b1;
    @(negedge clk);
    chk("t4_valid_T1", 1, 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    chk("t4_valid_T2", 1, 32'(rsp_valid[1]), 32'd0);
    corrupt[1] = 1'b0;
    @(negedge clk);
    chk("t4_valid_T3", 1, 32'(rsp_valid[1]), 32'd1);
    chk("t4_z",        1, 32'(rsp_z[1]), 32'h4);

    // asynchronous reset during WAIT, then during RESP
    @(negedge clk);
    send(0, 4'd7, 4'd1, 2'd0, t);
    #2 rst_n = 1'b0;
    #1;
    chk("t5w_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("t5w_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("t5w_count", 0, 32'(oc0), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    send(0, 4'd7, 4'd1, 2'd0, t);
    @(negedge clk);
    chk("t5r_valid_pre", 0, 32'(rsp_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("t5r_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("t5r_z",     0, 32'(rsp_z[0]), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    send(0, 4'd2, 4'd2, 2'd0, t);
    @(negedge clk);
    chk("t5_after_z", 0, 32'(rsp_z[0]), 32'd4);
    @(negedge clk);
    chk("t5_after_count", 0, 32'(oc0), 32'd1);

    // back-to-back ops on the 2-bit counter instance
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      send(1, 4'(i), 4'd1, 2'd0, t);
      if (i > 0) chk("t6_gap", 1, 32'(t - tprev), 32'd5);
      tprev = t;
      repeat (4) @(negedge clk);
      chk("t6_count", 1, 32'(oc1), 32'(exp6[i]));
    end

    // random traffic on both instances, occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_a[k]     = 4'($urandom);
        req_b[k]     = 4'($urandom);
        req_op[k]    = 2'($urandom);
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
